// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master: FSM state encoding and default timing.
package i2c_pkg;

    localparam int unsigned DefaultClkDiv = 125;

    typedef enum logic [3:0] {
        StIdle,
        StStart1,
        StStart2,
        StBit,
        StAck,
        StRestart1,
        StRestart2,
        StStop1,
        StStop2,
        StStop3
    } state_e;

endpackage

// File: rtl/i2c_clk_div.sv
// Quarter-SCL-period tick generator; counter is held at zero while disabled.
module i2c_clk_div #(
    parameter int unsigned CLK_DIV = 125,
    parameter int unsigned CNT_W   = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] Last = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == Last);

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            cnt <= '0;
        end else if (cnt == Last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/i2c_master.sv
// Byte-oriented I2C master with START/repeated START/STOP, ACK/NACK handling
// and open-drain style line enables. No clock stretching.
module i2c_master
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = DefaultClkDiv,
    parameter int unsigned CNT_W   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       send,
    input  logic       receive,
    input  logic [7:0] datasend,
    output logic       sended,
    output logic [7:0] datareceive,
    output logic       received,
    output logic       isReady,
    output logic       ack_error,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_in
);

    state_e     stateQ, stateD;
    logic [1:0] quarterQ, quarterD;
    logic [2:0] bitCntQ, bitCntD;
    logic [7:0] shiftQ, shiftD;
    logic [7:0] dataRxQ, dataRxD;
    logic       txQ, txD;
    logic       sendedQ, sendedD;
    logic       receivedQ, receivedD;
    logic       ackErrQ, ackErrD;
    logic       ackDriveQ, ackDriveD;
    logic       abortQ, abortD;
    logic       tick;
    logic       beginTx, beginRx;

    i2c_clk_div #(
        .CLK_DIV(CLK_DIV),
        .CNT_W  (CNT_W)
    ) uClkDiv (
        .clk  (clk),
        .reset(reset),
        .en   (stateQ != StIdle),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ    <= StIdle;
            quarterQ  <= '0;
            bitCntQ   <= '0;
            shiftQ    <= '0;
            dataRxQ   <= '0;
            txQ       <= 1'b0;
            sendedQ   <= 1'b0;
            receivedQ <= 1'b0;
            ackErrQ   <= 1'b0;
            ackDriveQ <= 1'b0;
            abortQ    <= 1'b0;
        end else begin
            stateQ    <= stateD;
            quarterQ  <= quarterD;
            bitCntQ   <= bitCntD;
            shiftQ    <= shiftD;
            dataRxQ   <= dataRxD;
            txQ       <= txD;
            sendedQ   <= sendedD;
            receivedQ <= receivedD;
            ackErrQ   <= ackErrD;
            ackDriveQ <= ackDriveD;
            abortQ    <= abortD;
        end
    end

    always_comb begin
        stateD    = stateQ;
        quarterD  = quarterQ;
        bitCntD   = bitCntQ;
        shiftD    = shiftQ;
        dataRxD   = dataRxQ;
        txD       = txQ;
        sendedD   = sendedQ;
        receivedD = receivedQ;
        ackErrD   = ackErrQ;
        ackDriveD = ackDriveQ;
        abortD    = abortQ;
        beginTx   = 1'b0;
        beginRx   = 1'b0;

        unique case (stateQ)
            StIdle: begin
                if (start && send) begin
                    stateD  = StStart1;
                    ackErrD = 1'b0;
                end
            end
            StStart1:   if (tick) stateD = StStart2;
            StStart2:   if (tick) beginTx = 1'b1;
            StBit: begin
                if (tick) begin
                    quarterD = quarterQ + 2'd1;
                    if (quarterQ == 2'd1 && !txQ) shiftD = {shiftQ[6:0], sda_in};
                    if (quarterQ == 2'd3) begin
                        if (txQ) shiftD = {shiftQ[6:0], 1'b0};
                        if (bitCntQ == 3'd7) begin
                            stateD  = StAck;
                            bitCntD = '0;
                            abortD  = 1'b0;
                            if (!txQ) begin
                                dataRxD   = shiftQ;
                                receivedD = 1'b1;
                                ackDriveD = receive;
                            end
                        end else begin
                            bitCntD = bitCntQ + 3'd1;
                        end
                    end
                end
            end
            StAck: begin
                if (tick) begin
                    quarterD = quarterQ + 2'd1;
                    // Slave ACK is sampled in the middle of the SCL-high window.
                    if (quarterQ == 2'd1 && txQ) begin
                        sendedD = 1'b0;
                        if (sda_in) begin
                            ackErrD = 1'b1;
                            abortD  = 1'b1;
                        end
                    end
                    if (quarterQ == 2'd3) begin
                        receivedD = 1'b0;
                        if (abortQ || (!txQ && !ackDriveQ)) stateD = StStop1;
                        else if (send && start)             stateD = StRestart1;
                        else if (send)                      beginTx = 1'b1;
                        else if (receive)                   beginRx = 1'b1;
                        else                                stateD = StStop1;
                    end
                end
            end
            StRestart1: if (tick) stateD = StRestart2;
            StRestart2: begin
                if (tick) begin
                    stateD  = StStart1;
                    ackErrD = 1'b0;
                end
            end
            StStop1:    if (tick) stateD = StStop2;
            StStop2:    if (tick) stateD = StStop3;
            StStop3:    if (tick) stateD = StIdle;
            default:    stateD = StIdle;
        endcase

        if (beginTx || beginRx) begin
            stateD   = StBit;
            quarterD = '0;
            bitCntD  = '0;
            txD      = beginTx;
        end
        if (beginTx) begin
            shiftD  = datasend;
            sendedD = 1'b1;
        end
    end

    // Line enables: 1 pulls the line low, 0 releases it.
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        unique case (stateQ)
            StStart1:   sda_oe = 1'b1;
            StStart2: begin
                scl_oe = 1'b1;
                sda_oe = 1'b1;
            end
            StBit: begin
                scl_oe = (quarterQ == 2'd0) || (quarterQ == 2'd3);
                sda_oe = txQ ? ~shiftQ[7] : 1'b0;
            end
            StAck: begin
                scl_oe = (quarterQ == 2'd0) || (quarterQ == 2'd3);
                sda_oe = txQ ? 1'b0 : ackDriveQ;
            end
            StRestart1: scl_oe = 1'b1;
            StStop1: begin
                scl_oe = 1'b1;
                sda_oe = 1'b1;
            end
            StStop2:    sda_oe = 1'b1;
            default: begin
                scl_oe = 1'b0;
                sda_oe = 1'b0;
            end
        endcase
    end

    assign sended      = sendedQ;
    assign received    = receivedQ;
    assign datareceive = dataRxQ;
    assign ack_error   = ackErrQ;
    assign isReady     = (stateQ == StIdle);

endmodule

// File: tb/tb_i2c_master.sv
// Directed testbench for i2c_master with a simple I2C slave bus-functional model.
module tb_i2c_master;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       send = 1'b0;
    logic       receive = 1'b0;
    logic [7:0] datasend = 8'h00;
    logic       sended, received, isReady, ack_error, scl_oe, sda_oe;
    logic [7:0] datareceive;
    logic       sclBus, sdaBus;

    int checks = 0;
    int failures = 0;

    // Slave model state
    logic       slaveLow = 1'b0;
    logic       slaveAck = 1'b1;
    logic       sclPrev = 1'b1;
    logic       sdaPrev = 1'b1;
    logic       slaveTx = 1'b0;
    logic       slaveDone = 1'b0;
    logic       rw = 1'b0;
    logic [7:0] rxByte = 8'h00;
    logic [7:0] curTx = 8'h00;
    logic [7:0] txData [0:7];
    logic [7:0] obsBytes [0:63];
    logic       ackBits [0:63];
    int bitIdx = -1;
    int nextIdx;
    int byteIdx = 0;
    int txPtr = 0;
    int obsCnt = 0;
    int ackCnt = 0;
    int startCnt = 0;
    int stopCnt = 0;

    assign sclBus = ~scl_oe;
    assign sdaBus = ~(sda_oe | slaveLow);

    i2c_master #(
        .CLK_DIV(4),
        .CNT_W  (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .send       (send),
        .receive    (receive),
        .datasend   (datasend),
        .sended     (sended),
        .datareceive(datareceive),
        .received   (received),
        .isReady    (isReady),
        .ack_error  (ack_error),
        .scl_oe     (scl_oe),
        .sda_oe     (sda_oe),
        .sda_in     (sdaBus)
    );

    always #5 clk = ~clk;

    always_comb nextIdx = (bitIdx == 8) ? 0 : bitIdx + 1;

    always @(posedge clk) begin
        sclPrev <= sclBus;
        sdaPrev <= sdaBus;
        if (sclPrev && sclBus && sdaPrev && !sdaBus) begin
            startCnt  <= startCnt + 1;
            bitIdx    <= -1;
            byteIdx   <= 0;
            txPtr     <= 0;
            slaveTx   <= 1'b0;
            slaveDone <= 1'b0;
            slaveLow  <= 1'b0;
            rw        <= 1'b0;
            rxByte    <= 8'h00;
        end else if (sclPrev && sclBus && !sdaPrev && sdaBus) begin
            stopCnt  <= stopCnt + 1;
            bitIdx   <= -1;
            slaveTx  <= 1'b0;
            slaveLow <= 1'b0;
        end else if (!sclPrev && sclBus) begin
            if (bitIdx >= 0 && bitIdx < 8 && !slaveTx) rxByte <= {rxByte[6:0], sdaBus};
            if (bitIdx == 8 && slaveTx) begin
                ackBits[ackCnt] <= sdaBus;
                ackCnt <= ackCnt + 1;
                if (sdaBus) slaveDone <= 1'b1;
            end
        end else if (sclPrev && !sclBus) begin
            bitIdx <= nextIdx;
            if (bitIdx == 7 && !slaveTx) begin
                obsBytes[obsCnt] <= rxByte;
                obsCnt <= obsCnt + 1;
                if (byteIdx == 0) rw <= rxByte[0];
            end
            if (bitIdx == 8) byteIdx <= byteIdx + 1;
            if (nextIdx == 8) begin
                slaveLow <= !slaveTx && slaveAck;
            end else if (bitIdx == 8 && (slaveTx || (byteIdx == 0 && rw)) && !slaveDone) begin
                curTx    <= txData[txPtr];
                txPtr    <= txPtr + 1;
                slaveTx  <= 1'b1;
                slaveLow <= ~txData[txPtr][7];
            end else if (slaveTx && !slaveDone && nextIdx >= 1 && nextIdx <= 7) begin
                slaveLow <= ~curTx[7-nextIdx];
            end else begin
                slaveLow <= 1'b0;
            end
        end
    end

    function automatic logic sigSel(input int sel);
        case (sel)
            0:       return sended;
            1:       return received;
            default: return isReady;
        endcase
    endfunction

    task automatic waitFor(input int sel, input logic level, input string name);
        int n = 0;
        while (sigSel(sel) !== level && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sigSel(sel) !== level) begin
            $display("FAIL %s: timed out, value=%b required=%b", name, sigSel(sel), level);
            failures++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks += 7;
        if (scl_oe !== 1'b0) begin $display("FAIL rst_scl: got %b want 0", scl_oe); failures++; end
        if (sda_oe !== 1'b0) begin $display("FAIL rst_sda: got %b want 0", sda_oe); failures++; end
        if (sended !== 1'b0) begin $display("FAIL rst_sended: got %b want 0", sended); failures++; end
        if (received !== 1'b0) begin $display("FAIL rst_received: got %b want 0", received); failures++; end
        if (datareceive !== 8'h00) begin
            $display("FAIL rst_data: got %h want 00", datareceive); failures++;
        end
        if (ack_error !== 1'b0) begin $display("FAIL rst_ackerr: got %b want 0", ack_error); failures++; end
        if (isReady !== 1'b1) begin $display("FAIL rst_ready: got %b want 1", isReady); failures++; end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write;
        int hi = 0;
        int o0 = obsCnt;
        int s0 = startCnt;
        int p0 = stopCnt;
        slaveAck = 1'b1;
        datasend = 8'hEE; start = 1'b1; send = 1'b1;
        waitFor(0, 1'b1, "wr_sended_rise");
        start = 1'b0; send = 1'b0; datasend = 8'h00;
        while (sended === 1'b1 && hi < 1000) begin
            @(negedge clk);
            hi++;
        end
        checks++;
        if (hi != 136) begin $display("FAIL wr_sended_len: got %0d want 136", hi); failures++; end
        waitFor(2, 1'b1, "wr_idle");
        checks += 5;
        if (obsCnt != o0 + 1) begin $display("FAIL wr_nbytes: got %0d want %0d", obsCnt - o0, 1); failures++; end
        if (obsBytes[o0] !== 8'hEE) begin $display("FAIL wr_byte: got %h want ee", obsBytes[o0]); failures++; end
        if (startCnt != s0 + 1) begin $display("FAIL wr_start: got %0d want 1", startCnt - s0); failures++; end
        if (stopCnt != p0 + 1) begin $display("FAIL wr_stop: got %0d want 1", stopCnt - p0); failures++; end
        if (ack_error !== 1'b0) begin $display("FAIL wr_ackerr: got %b want 0", ack_error); failures++; end
    endtask

    task automatic test_restart_read;
        int hi = 0;
        int nackBad = 0;
        int o0 = obsCnt;
        int s0 = startCnt;
        int p0 = stopCnt;
        int a0 = ackCnt;
        txData[0] = 8'h55;
        slaveAck = 1'b1;
        datasend = 8'hEE; start = 1'b1; send = 1'b1;
        waitFor(0, 1'b1, "rr_ee_rise");
        start = 1'b0; datasend = 8'hD0;
        waitFor(0, 1'b0, "rr_ee_fall");
        waitFor(0, 1'b1, "rr_d0_rise");
        start = 1'b1; datasend = 8'hEF;
        waitFor(0, 1'b0, "rr_d0_fall");
        waitFor(0, 1'b1, "rr_ef_rise");
        start = 1'b0; send = 1'b0; receive = 1'b1;
        waitFor(0, 1'b0, "rr_ef_fall");
        repeat (40) @(negedge clk);
        receive = 1'b0;
        waitFor(1, 1'b1, "rr_received_rise");
        checks++;
        if (datareceive !== 8'h55) begin $display("FAIL rr_data: got %h want 55", datareceive); failures++; end
        while (received === 1'b1 && hi < 1000) begin
            if (sda_oe !== 1'b0) nackBad++;
            @(negedge clk);
            hi++;
        end
        checks += 2;
        if (hi != 16) begin $display("FAIL rr_received_len: got %0d want 16", hi); failures++; end
        if (nackBad != 0) begin $display("FAIL rr_nack_drive: low cycles=%0d want 0", nackBad); failures++; end
        waitFor(2, 1'b1, "rr_idle");
        checks += 8;
        if (obsCnt != o0 + 3) begin $display("FAIL rr_nbytes: got %0d want 3", obsCnt - o0); failures++; end
        if (obsBytes[o0] !== 8'hEE) begin $display("FAIL rr_byte0: got %h want ee", obsBytes[o0]); failures++; end
        if (obsBytes[o0+1] !== 8'hD0) begin $display("FAIL rr_byte1: got %h want d0", obsBytes[o0+1]); failures++; end
        if (obsBytes[o0+2] !== 8'hEF) begin $display("FAIL rr_byte2: got %h want ef", obsBytes[o0+2]); failures++; end
        if (startCnt != s0 + 2) begin $display("FAIL rr_starts: got %0d want 2", startCnt - s0); failures++; end
        if (stopCnt != p0 + 1) begin $display("FAIL rr_stop: got %0d want 1", stopCnt - p0); failures++; end
        if (ackCnt != a0 + 1) begin $display("FAIL rr_nacks: got %0d want 1", ackCnt - a0); failures++; end
        if (ackBits[a0] !== 1'b1) begin $display("FAIL rr_nack_bit: got %b want 1", ackBits[a0]); failures++; end
    endtask

    task automatic test_nack;
        int p0 = stopCnt;
        slaveAck = 1'b0;
        datasend = 8'hEE; start = 1'b1; send = 1'b1;
        waitFor(0, 1'b1, "nk_sended_rise");
        start = 1'b0;
        waitFor(2, 1'b1, "nk_idle");
        checks += 2;
        if (ack_error !== 1'b1) begin $display("FAIL nk_ackerr: got %b want 1", ack_error); failures++; end
        if (stopCnt != p0 + 1) begin $display("FAIL nk_stop: got %0d want 1", stopCnt - p0); failures++; end
        repeat (20) @(negedge clk);
        checks += 3;
        if (isReady !== 1'b1) begin $display("FAIL nk_send_ignored: got %b want 1", isReady); failures++; end
        if (scl_oe !== 1'b0) begin $display("FAIL nk_idle_scl: got %b want 0", scl_oe); failures++; end
        if (ack_error !== 1'b1) begin $display("FAIL nk_sticky: got %b want 1", ack_error); failures++; end
        slaveAck = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        checks += 2;
        if (ack_error !== 1'b0) begin $display("FAIL nk_cleared: got %b want 0", ack_error); failures++; end
        if (isReady !== 1'b0) begin $display("FAIL nk_busy: got %b want 0", isReady); failures++; end
        waitFor(0, 1'b1, "nk2_sended_rise");
        start = 1'b0; send = 1'b0;
        waitFor(2, 1'b1, "nk2_idle");
    endtask

    task automatic test_read_burst;
        logic [7:0] expData [0:2];
        logic       expAck [0:2];
        int a0 = ackCnt;
        expData[0] = 8'hA1; expData[1] = 8'hB2; expData[2] = 8'hC3;
        expAck[0] = 1'b0; expAck[1] = 1'b0; expAck[2] = 1'b1;
        for (int i = 0; i < 3; i++) txData[i] = expData[i];
        slaveAck = 1'b1;
        datasend = 8'hEF; start = 1'b1; send = 1'b1;
        waitFor(0, 1'b1, "rb_sended_rise");
        start = 1'b0; send = 1'b0; receive = 1'b1;
        for (int i = 0; i < 3; i++) begin
            waitFor(1, 1'b1, "rb_received_rise");
            checks += 2;
            if (datareceive !== expData[i]) begin
                $display("FAIL rb_data%0d: got %h want %h", i, datareceive, expData[i]); failures++;
            end
            if (sda_oe !== ~expAck[i]) begin
                $display("FAIL rb_ackdrv%0d: got %b want %b", i, sda_oe, ~expAck[i]); failures++;
            end
            waitFor(1, 1'b0, "rb_received_fall");
            if (i == 1) begin
                repeat (30) @(negedge clk);
                receive = 1'b0;
            end
        end
        waitFor(2, 1'b1, "rb_idle");
        checks++;
        if (ackCnt != a0 + 3) begin $display("FAIL rb_nacks: got %0d want 3", ackCnt - a0); failures++; end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ackBits[a0+i] !== expAck[i]) begin
                $display("FAIL rb_ackbit%0d: got %b want %b", i, ackBits[a0+i], expAck[i]); failures++;
            end
        end
    endtask

    task automatic test_reset_mid;
        datasend = 8'hEE; start = 1'b1; send = 1'b1;
        waitFor(0, 1'b1, "rm_sended_rise");
        start = 1'b0; send = 1'b0;
        repeat (4 * 16 + 6) @(negedge clk);
        checks++;
        if (isReady !== 1'b0) begin $display("FAIL rm_busy: got %b want 0", isReady); failures++; end
        reset = 1'b1;
        @(negedge clk);
        checks += 4;
        if (scl_oe !== 1'b0) begin $display("FAIL rm_scl: got %b want 0", scl_oe); failures++; end
        if (sda_oe !== 1'b0) begin $display("FAIL rm_sda: got %b want 0", sda_oe); failures++; end
        if (isReady !== 1'b1) begin $display("FAIL rm_ready: got %b want 1", isReady); failures++; end
        if (sended !== 1'b0) begin $display("FAIL rm_sended: got %b want 0", sended); failures++; end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (scl_oe !== 1'b0) begin $display("FAIL rm_stay_idle: got %b want 0", scl_oe); failures++; end
    endtask

    task automatic test_back_to_back;
        int o0 = obsCnt;
        slaveAck = 1'b1;
        datasend = 8'hEE; start = 1'b1; send = 1'b1;
        waitFor(0, 1'b1, "bb_sended_rise");
        start = 1'b0; receive = 1'b1; datasend = 8'h3C;
        waitFor(0, 1'b0, "bb_sended_fall");
        waitFor(0, 1'b1, "bb_sended_rise2");
        send = 1'b0; receive = 1'b0;
        checks++;
        if (received !== 1'b0) begin $display("FAIL bb_no_rx: got %b want 0", received); failures++; end
        waitFor(2, 1'b1, "bb_idle");
        checks += 2;
        if (obsCnt != o0 + 2) begin $display("FAIL bb_nbytes: got %0d want 2", obsCnt - o0); failures++; end
        if (obsBytes[o0+1] !== 8'h3C) begin $display("FAIL bb_byte: got %h want 3c", obsBytes[o0+1]); failures++; end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) txData[i] = 8'hFF;
        @(negedge clk);
        test_reset();
        test_write();
        test_restart_read();
        test_nack();
        test_read_burst();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
Parameters:
REQ-001 CLK_DIV, default 125, clk cycles per quarter SCL period (50 MHz -> 100 kHz SCL).
REQ-002 CNT_W, default 16, width of the quarter-period counter; it SHALL satisfy CLK_DIV < 2^CNT_W.
Ports:
REQ-003 clk  in  1  single clock; all logic SHALL be rising-edge clocked on clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  when high together with send at a byte boundary, issue START (or repeated START if the bus is already owned) before that byte.
REQ-006 send  in  1  transmit bytes from datasend for as long as send is high.
REQ-007 receive  in  1  receive bytes for as long as receive is high.
REQ-008 datasend  in  8  byte to transmit (address+R/W or data), MSB first.
REQ-009 sended  out  1  high from datasend capture until ACK-bit sampling.
REQ-010 datareceive  out  8  last received byte.
REQ-011 received  out  1  high during the ACK/NACK bit of a received byte; datareceive is valid while received is high.
REQ-012 isReady  out  1  high only in IDLE with the bus released.
REQ-013 ack_error  out  1  sticky flag: slave NACKed a transmitted byte; cleared by the next START.
REQ-014 scl_oe  out  1  1 drives SCL low; 0 releases SCL.
REQ-015 sda_oe  out  1  1 drives SDA low; 0 releases SDA.
REQ-016 sda_in  in  1  sampled SDA line.

Function
REQ-017 A quarter-tick SHALL pulse once every CLK_DIV clk cycles while the FSM is outside IDLE; its counter SHALL be held at 0 in IDLE.
REQ-018 FSM states SHALL be IDLE, START1, START2, BIT, ACK, RESTART1, RESTART2, STOP1, STOP2, STOP3; every non-IDLE state SHALL last 4 quarter-ticks except START*/RESTART*/STOP*, which last 1.
REQ-019 IDLE -> START1 when start&send; send without start in IDLE SHALL be ignored.
REQ-020 START: SDA falls while SCL is high, then SCL falls.
REQ-021 Entering BIT for a transmit byte SHALL capture datasend into a shift register and raise sended in the same cycle.
REQ-022 BIT: SDA changes only while SCL is low (quarter 0); SCL is high during quarters 1-2; the receive bit is sampled at the end of quarter 1; there are 8 bits, MSB first.
REQ-023 ACK (transmit): SDA is released, sda_in is sampled at mid-SCL-high, and sended drops at that sample; sda_in=1 SHALL set ack_error and go to STOP1.
REQ-024 ACK (receive): datareceive is loaded and received rises at ACK entry; the master drives ACK (SDA low) if receive is still high at ACK entry, otherwise NACK; received drops at the end of ACK.
REQ-025 After ACK: send&start -> RESTART1; send -> BIT (transmit); receive -> BIT (receive); otherwise -> STOP1.
REQ-026 A receive transfer that ended with NACK SHALL go to STOP1 regardless of inputs.
REQ-027 Direction SHALL be chosen at byte boundaries only; if send and receive are both high, send SHALL win.
REQ-028 STOP: SDA low, SCL released, then SDA released; STOP3 -> IDLE.
REQ-029 Clock stretching SHALL NOT be supported; the SCL input is not monitored.
REQ-030 Changes to inputs mid-byte SHALL have no effect until the next byte boundary.

Reset
REQ-031 With reset high at a clk edge: state=IDLE, scl_oe=0, sda_oe=0, sended=0, received=0, datareceive=8'h00, ack_error=0, isReady=1 on the next edge, counters=0.
REQ-032 Reset mid-transfer SHALL release both lines immediately without generating a STOP.

Structure
REQ-033 State encodings and the default CLK_DIV SHALL live in the shared package i2c_pkg.
REQ-034 The quarter-tick generator SHALL be a sub-module i2c_clk_div (parameters CLK_DIV, CNT_W; inputs clk, reset, en; output tick).

Verification (CLK_DIV=4, slave bus-functional model)
REQ-035 start=1, send=1, datasend=8'hEE, slave ACK -> START on the bus, byte EE observed, sended high for 8 bits, ack_error=0.
REQ-036 Sequence EE (start), D0, then EF (start), then receive for one byte with slave data 8'h55 and receive dropped -> repeated START, datareceive=8'h55, received pulse, NACK, STOP, isReady=1.
REQ-037 Slave NACKs address 8'hEE -> ack_error=1, STOP, IDLE; the next START clears ack_error.
REQ-038 receive held for 3 bytes (A1, B2, C3) -> ACK, ACK, NACK; datareceive matches each byte while received is high.
REQ-039 reset asserted during bit 4 -> scl_oe=sda_oe=0 and isReady=1 on the next edge.
REQ-040 send and receive both high at a byte boundary -> a transmit byte is performed.
